// File: rtl/mux_two_16bit.sv
// Two-input WIDTH-bit selector with a registered output.
// The result appears one clock after the inputs. Reset is asynchronous and clears the result.
module mux_two_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] select1,
  input  logic [WIDTH-1:0] select2,
  input  logic             control,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] result_d;

  // Only a definite 1 picks select2; 0, X and Z all fall back to select1.
  always_comb begin
    result_d = select1;
    if (control == 1'b1) begin
      result_d = select2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else begin
      result <= result_d;
    end
  end

endmodule

// File: tb/tb_mux_two_16bit.sv
// Directed bench for mux_two_16bit: reset behaviour, selection, latency and boundary data.
module tb_mux_two_16bit;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] select1;
  logic [WIDTH-1:0] select2;
  logic             control;
  logic [WIDTH-1:0] result;

  int n_compared;
  int n_mismatched;

  mux_two_16bit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .select1 (select1),
    .select2 (select2),
    .control (control),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_v;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset   = 1'b0;
    select1 = 16'h0000;
    select2 = 16'h0001;
    control = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_immediate", result, 16'h0000);
    control = 1'b1;
    step();
    check_eq("rst_hold_edge1", result, 16'h0000);
    step();
    check_eq("rst_hold_edge2", result, 16'h0000);
    @(negedge clk);
    control = 1'b0;
    reset   = 1'b0;
    step();
    check_eq("rst_release", result, 16'h0000);

    // Basic selection and one-cycle latency.
    @(negedge clk);
    control = 1'b0;
    step();
    check_eq("basic_ctl0", result, 16'h0000);
    @(negedge clk);
    control = 1'b1;
    #1;
    check_eq("basic_not_before_edge", result, 16'h0000);
    step();
    check_eq("basic_ctl1", result, 16'h0001);

    // Alternating full-width patterns.
    @(negedge clk);
    select1 = 16'hA5A5;
    select2 = 16'h5A5A;
    for (int i = 0; i < 8; i++) begin
      control = i[0];
      exp_v   = i[0] ? 16'h5A5A : 16'hA5A5;
      #1;
      check_eq("toggle_lag", result, (i == 0) ? 16'h0001 : (i[0] ? 16'hA5A5 : 16'h5A5A));
      step();
      check_eq("toggle", result, exp_v);
      @(negedge clk);
    end

    // Boundary data.
    select1 = 16'hFFFF; select2 = 16'h0000; control = 1'b0;
    step(); check_eq("bound_ffff", result, 16'hFFFF);
    @(negedge clk); control = 1'b1;
    step(); check_eq("bound_0000", result, 16'h0000);
    @(negedge clk); select1 = 16'h8000; select2 = 16'h0001; control = 1'b0;
    step(); check_eq("bound_8000", result, 16'h8000);
    @(negedge clk); control = 1'b1;
    step(); check_eq("bound_0001", result, 16'h0001);

    // Inputs and control changing together.
    @(negedge clk); select1 = 16'h3C3C; select2 = 16'hC3C3; control = 1'b0;
    step(); check_eq("simul_change", result, 16'h3C3C);

    // Asynchronous reset pulse mid-operation.
    @(negedge clk); control = 1'b1; select2 = 16'h1234;
    step(); check_eq("mid_loaded", result, 16'h1234);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_immediate", result, 16'h0000);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_released_no_edge", result, 16'h0000);
    step(); check_eq("mid_reload", result, 16'h1234);

    // Unknown control falls back to select1.
    @(negedge clk); control = 1'bx; select1 = 16'h00FF; select2 = 16'hFF00;
    step(); check_eq("ctl_unknown", result, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
